// File: rtl/sap1_prog_loader.sv
// SAP-1 program loader: fills the 16x8 program RAM from a byte stream while holding the CPU in reset.
// Optional trailing checksum byte verification is enabled with `define SAP1_LOADER_CHECKSUM_EN.
module sap1_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd3;
`ifdef SAP1_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ERROR = 3'd4;
`endif

  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              xfer;
  logic              go_load;

  assign xfer = in_valid & in_ready;

`ifdef SAP1_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_chk;
  logic              error_q;

  assign sum_chk = sum + in_data;
  assign error   = error_q;
  // start is honoured from every state except the two that consume stream bytes
  assign go_load = start & (state != S_LOAD) & (state != S_CHECK);
`else
  assign error   = 1'b0;
  assign go_load = start & (state != S_LOAD);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
`ifdef SAP1_LOADER_CHECKSUM_EN
      sum       <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (go_load) begin
        state    <= S_LOAD;
        cnt      <= '0;
        in_ready <= 1'b1;
        cpu_rst  <= 1'b1;
        done     <= 1'b0;
`ifdef SAP1_LOADER_CHECKSUM_EN
        sum      <= '0;
        error_q  <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: ;
          S_LOAD: begin
            if (xfer) begin
              mem_we    <= 1'b1;
              mem_addr  <= cnt;
              mem_wdata <= in_data;
              cnt       <= cnt + 1'b1;
`ifdef SAP1_LOADER_CHECKSUM_EN
              sum       <= sum_chk;
              if (cnt == LAST) state <= S_CHECK;
`else
              if (cnt == LAST) begin
                state    <= S_RUN;
                in_ready <= 1'b0;
              end
`endif
            end
          end
`ifdef SAP1_LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (xfer) begin
              in_ready <= 1'b0;
              if (sum_chk == '0) begin
                state <= S_RUN;
              end else begin
                state   <= S_ERROR;
                error_q <= 1'b1;
              end
            end
          end
          S_ERROR: ;
`endif
          S_RUN: begin
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Scoreboard bench for sap1_prog_loader: transfers push expected RAM writes, the write monitor pops them.
module tb_sap1_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst;
  logic       done;
  logic       error;

  sap1_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [7:0]  d;
    int unsigned c;
  } wr_t;

  wr_t         sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned sess_xfers = 0;
  int unsigned total_xfers = 0;
  int unsigned wr_count = 0;
  int unsigned sess_w0 = 0;
  int unsigned sess_x0 = 0;
  logic [3:0]  tb_addr = '0;

  // Each of the first 16 accepted bytes of a session must reach RAM at the next address.
  always @(posedge clk) begin
    cyc++;
    if (in_valid === 1'b1 && in_ready === 1'b1) begin
      total_xfers++;
      if (sess_xfers < 16) begin
        sb.push_back('{a: tb_addr, d: in_data, c: cyc});
        tb_addr++;
        sess_xfers++;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      wr_count++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write got addr=%h data=%h required no write", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.a || mem_wdata !== e.d || cyc !== e.c) begin
          miscompares++;
          $display("FAIL ram_write got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                   mem_addr, mem_wdata, cyc, e.a, e.d, e.c);
        end
      end
    end
  end

  task automatic begin_session();
    tb_addr    = '0;
    sess_xfers = 0;
    sess_w0    = wr_count;
    sess_x0    = total_xfers;
  endtask

  task automatic start_load();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    vectors++;
    if ({in_ready, cpu_rst, done, error} !== 4'b1100) begin
      miscompares++;
      $display("FAIL start_to_load got ready/cpu_rst/done/err=%b required 1100",
               {in_ready, cpu_rst, done, error});
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int tries;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1; in_valid = 1'b0;
    end
    @(posedge clk); #1; in_valid = 1'b1; in_data = d;
    tries = 0;
    while (in_ready !== 1'b1 && tries < 50) begin
      @(posedge clk); #1; tries++;
    end
    if (tries >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout got in_ready=%b required 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic end_session(input logic [7:0] sum);
    int unsigned exp_x;
    exp_x = 16;
`ifdef SAP1_LOADER_CHECKSUM_EN
    send_byte(8'h00 - sum, 0);
    exp_x = 17;
`endif
    @(posedge clk); #1; in_data = 8'hEE;
    vectors++;
    if ({in_ready, cpu_rst, done, error} !== 4'b0100) begin
      miscompares++;
      $display("FAIL run_entry got ready/cpu_rst/done/err=%b required 0100",
               {in_ready, cpu_rst, done, error});
    end
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, cpu_rst, done, error} !== 4'b0010) begin
      miscompares++;
      $display("FAIL run_outputs got ready/cpu_rst/done/err=%b required 0010",
               {in_ready, cpu_rst, done, error});
    end
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (wr_count - sess_w0 !== 16 || sb.size() != 0 || total_xfers - sess_x0 !== exp_x) begin
      miscompares++;
      $display("FAIL session_count got writes=%0d pending=%0d accepts=%0d required 16 0 %0d",
               wr_count - sess_w0, sb.size(), total_xfers - sess_x0, exp_x);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #100;
    vectors++;
    if ({in_ready, mem_we, cpu_rst, done, error} !== 5'b00100 || mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state got ready/we/cpu_rst/done/err=%b addr=%h data=%h required 00100 0 00",
               {in_ready, mem_we, cpu_rst, done, error}, mem_addr, mem_wdata);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({in_ready, mem_we, cpu_rst, done, error} !== 5'b00100) begin
        miscompares++;
        $display("FAIL idle_state cycle %0d got ready/we/cpu_rst/done/err=%b required 00100",
                 i, {in_ready, mem_we, cpu_rst, done, error});
      end
    end
  endtask

  task automatic test_full_load();
    logic [7:0] sum;
    sum = '0;
    begin_session();
    start_load();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h10 + 8'(i), 0);
      sum += 8'h10 + 8'(i);
    end
    end_session(sum);
  endtask

  task automatic test_throttled();
    logic [7:0] sum;
    sum = '0;
    begin_session();
    start_load();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'hA0 + 8'(i), 2);
      sum += 8'hA0 + 8'(i);
    end
    end_session(sum);
  endtask

  task automatic test_reprogram();
    begin_session();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; in_valid = 1'b1; in_data = 8'h55;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL run_ignores_bytes got in_ready=%b required 0", in_ready);
      end
    end
    @(posedge clk); #1; in_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    vectors++;
    if ({cpu_rst, done, in_ready} !== 3'b101 || wr_count != sess_w0) begin
      miscompares++;
      $display("FAIL reprogram_entry got cpu_rst/done/ready=%b writes=%0d required 101 0",
               {cpu_rst, done, in_ready}, wr_count - sess_w0);
    end
    for (int i = 0; i < 16; i++) send_byte(8'h00, 0);
    end_session(8'h00);
  endtask

  task automatic test_reset_midload();
    logic [7:0] sum;
    begin_session();
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 0);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); #1; rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, mem_we, cpu_rst, done, error} !== 5'b00100 || mem_addr !== 4'h0 || mem_wdata !== 8'h00
        || wr_count - sess_w0 !== 5 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL midload_reset got ready/we/cpu_rst/done/err=%b addr=%h data=%h writes=%0d required 00100 0 00 5",
               {in_ready, mem_we, cpu_rst, done, error}, mem_addr, mem_wdata, wr_count - sess_w0);
    end
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    sum = '0;
    begin_session();
    start_load();
    for (int i = 0; i < 16; i++) begin
      if (i == 8) start = 1'b1;
      send_byte(8'h30 + 8'(i), 0);
      if (i == 10) start = 1'b0;
      sum += 8'h30 + 8'(i);
    end
    start = 1'b0;
    end_session(sum);
  endtask

`ifdef SAP1_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    begin_session();
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    end_session(8'h78);

    begin_session();
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    send_byte(8'h87, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    vectors++;
    if ({error, cpu_rst, in_ready, done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL bad_checksum got err/cpu_rst/ready/done=%b required 1100", {error, cpu_rst, in_ready, done});
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({error, cpu_rst, in_ready, done} !== 4'b1100 || wr_count - sess_w0 !== 16 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL error_hold got err/cpu_rst/ready/done=%b writes=%0d required 1100 16",
               {error, cpu_rst, in_ready, done}, wr_count - sess_w0);
    end
    begin_session();
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'h01, 0);
    end_session(8'h10);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required $finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_load();
    test_throttled();
    test_reprogram();
    test_reset_midload();
`ifdef SAP1_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
